// File: rtl/vp_recovery_pkg.sv
// Shared types for the value-prediction recovery unit; supplies default
// `ADDR_WIDTH / `DATA_WIDTH when the build does not define them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package vp_recovery_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_ROLLBACK,
        ST_REDIRECT
    } vp_rec_state_e;

    typedef struct packed {
        logic [4:0]             reg_idx;
        logic [`DATA_WIDTH-1:0] data;
    } undo_entry_t;

    localparam int unsigned DEFAULT_LOG_DEPTH = 8;
    localparam int unsigned LOG_PTR_W         = $clog2(DEFAULT_LOG_DEPTH);

    function automatic int unsigned log_ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/vp_undo_stack.sv
// LIFO of undo entries; the owner guarantees no push when full, no pop when
// empty, and never push and pop in the same cycle.
module vp_undo_stack
    import vp_recovery_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_LOG_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  undo_entry_t                  push_entry,
    output undo_entry_t                  top,
    output logic [log_ptr_width(DEPTH):0] count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = log_ptr_width(DEPTH);
    localparam int unsigned CW    = PTR_W + 1;

    undo_entry_t      mem [DEPTH];
    logic [CW-1:0]    top_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (push)
            count <= count + 1'b1;
        else if (pop)
            count <= count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[count[PTR_W-1:0]] <= push_entry;
    end

    // Wraps to the last slot when empty; consumers gate on empty.
    assign top_idx = count - 1'b1;
    assign top     = mem[top_idx[PTR_W-1:0]];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/vp_recovery_unit.sv
// Value-prediction recovery responder: logs speculative writes, rolls them back
// newest-first on recover, then redirects fetch. Stats gated by VP_RECOVERY_STATS_EN.
module vp_recovery_unit
    import vp_recovery_pkg::*;
#(
    parameter int unsigned LOG_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vp_lock,
    input  logic                   vp_done,
    input  logic                   recover,
    input  logic [`ADDR_WIDTH-1:0] predicted_pc,
    input  logic                   spec_wr_valid,
    input  logic [4:0]             spec_wr_reg,
    input  logic [`DATA_WIDTH-1:0] spec_wr_old_data,
    output logic                   recover_en,
    output logic                   stall,
    output logic                   flush,
    output logic                   undo_wr_valid,
    output logic [4:0]             undo_wr_reg,
    output logic [`DATA_WIDTH-1:0] undo_wr_data,
    output logic                   redirect_valid,
    output logic [`ADDR_WIDTH-1:0] redirect_pc,
    output logic                   recovery_done,
    output logic [31:0]            stat_recoveries,
    output logic [31:0]            stat_confirms,
    output logic [31:0]            stat_stalls
);

    localparam int unsigned CW = log_ptr_width(LOG_DEPTH) + 1;

    vp_rec_state_e          state, next_state;
    logic [`ADDR_WIDTH-1:0] pc_q;
    logic                   push, pop, clear, capture;
    logic                   full, empty;
    logic [CW-1:0]          log_count;
    undo_entry_t            push_entry, top;

    assign push_entry = '{reg_idx: spec_wr_reg, data: spec_wr_old_data};

    vp_undo_stack #(.DEPTH(LOG_DEPTH)) u_stack (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .clear      (clear),
        .push_entry (push_entry),
        .top        (top),
        .count      (log_count),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pc_q  <= '0;
        end else begin
            state <= next_state;
            if (capture)
                pc_q <= predicted_pc;
        end
    end

    always_comb begin
        next_state     = state;
        push           = 1'b0;
        pop            = 1'b0;
        clear          = 1'b0;
        capture        = 1'b0;
        recover_en     = 1'b0;
        stall          = 1'b0;
        flush          = 1'b0;
        undo_wr_valid  = 1'b0;
        undo_wr_reg    = '0;
        undo_wr_data   = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        recovery_done  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (vp_lock) begin
                    next_state = ST_TRACK;
                    clear      = 1'b1;
                    capture    = 1'b1;
                end
            end
            ST_TRACK: begin
                recover_en = 1'b1;
                stall      = full;
                // A write in the recover cycle is logged so rollback covers it.
                push       = spec_wr_valid && (spec_wr_reg != '0) && !full;
                if (recover) begin
                    next_state = ST_ROLLBACK;
                end else if (vp_done) begin
                    next_state = ST_IDLE;
                    clear      = 1'b1;
                end
            end
            ST_ROLLBACK: begin
                flush = 1'b1;
                if (empty) begin
                    next_state = ST_REDIRECT;
                end else begin
                    pop           = 1'b1;
                    undo_wr_valid = 1'b1;
                    undo_wr_reg   = top.reg_idx;
                    undo_wr_data  = top.data;
                    if (log_count == CW'(1))
                        next_state = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = pc_q;
                recovery_done  = 1'b1;
                next_state     = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

`ifdef VP_RECOVERY_STATS_EN
    logic [31:0] recoveries_q, confirms_q, stalls_q;
    logic        confirm;

    assign confirm = (state == ST_TRACK) && vp_done && !recover;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            recoveries_q <= '0;
            confirms_q   <= '0;
            stalls_q     <= '0;
        end else begin
            if ((state == ST_REDIRECT) && (recoveries_q != '1))
                recoveries_q <= recoveries_q + 32'd1;
            if (confirm && (confirms_q != '1))
                confirms_q <= confirms_q + 32'd1;
            if (stall && (stalls_q != '1))
                stalls_q <= stalls_q + 32'd1;
        end
    end

    assign stat_recoveries = recoveries_q;
    assign stat_confirms   = confirms_q;
    assign stat_stalls     = stalls_q;
`else
    assign stat_recoveries = '0;
    assign stat_confirms   = '0;
    assign stat_stalls     = '0;
`endif

endmodule

// File: doc/vp_recovery_unit.md
# vp_recovery_unit

Responder side of the value-prediction handshake: tracks the speculation window opened by the value predictor, logs every speculative register write, and on a misprediction `recover` pulse rolls the register file back, flushes the pipeline, redirects fetch to the predicted load's PC, and answers with `recovery_done`. Sits between the value predictor, the writeback stage, the register file restore port and fetch.

## Interface
Parameters:
- LOG_DEPTH, 8: undo-log entries (power of two, ≥2)

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- vp_lock  in  1  predictor speculation window open
- vp_done  in  1  predictor confirmed prediction correct
- recover  in  1  predictor misprediction pulse
- predicted_pc  in  `ADDR_WIDTH  PC of the predicted load
- spec_wr_valid  in  1  writeback writing a register this cycle
- spec_wr_reg  in  5  destination register index
- spec_wr_old_data  in  `DATA_WIDTH  value being overwritten, read from the register file
- recover_en  out  1  predictor may compare/recover (high in TRACK)
- stall  out  1  writeback must hold (log full in TRACK)
- flush  out  1  pipeline flush (ROLLBACK and REDIRECT)
- undo_wr_valid / undo_wr_reg / undo_wr_data  out  1 / 5 / `DATA_WIDTH  register file restore write
- redirect_valid  out  1  fetch redirect pulse
- redirect_pc  out  `ADDR_WIDTH  redirect target
- recovery_done  out  1  rollback complete pulse
- stat_recoveries, stat_confirms, stat_stalls  out  32 each  statistics (see Configuration)

## Operation
- States: IDLE, TRACK, ROLLBACK, REDIRECT.
- IDLE: vp_lock=1 → capture predicted_pc, clear log, go TRACK. Other inputs ignored.
- TRACK: spec_wr_valid=1 with spec_wr_reg≠0 and log not full → push {reg, old_data}. Writes to $0 never logged. Duplicate registers logged each time; LIFO restore yields the oldest value.
- stall = TRACK & log full. A write presented while stall=1 is not logged (writeback holds it).
- TRACK, recover=1 → ROLLBACK. A same-cycle spec_wr_valid is pushed first and included in rollback.
- TRACK, vp_done=1 (recover=0) → IDLE, log discarded. recover and vp_done together: recover wins.
- ROLLBACK: pop one entry per cycle, newest first, driving undo_wr_* that cycle. Last pop → REDIRECT. Empty log on entry → REDIRECT the following cycle with no undo writes.
- REDIRECT: one cycle, redirect_valid=1, redirect_pc=captured PC, recovery_done=1 → IDLE.
- recover/vp_done outside TRACK ignored.

## Timing
- Reset: state IDLE, log count 0, captured PC 0, every output 0.
- recover sampled at edge N with k logged entries: undo writes in cycles N+1..N+k, REDIRECT in cycle N+k+1, IDLE at N+k+2.
- flush high every ROLLBACK and REDIRECT cycle.
- recover_en, stall, flush, undo_wr_*, redirect_*, recovery_done are decoded combinationally from registered state/log only, never from same-cycle inputs.
- vp_lock capture to TRACK: 1 cycle; recover_en high from the next cycle.
- Reset mid-rollback: immediate return to IDLE; partial restore abandoned, no redirect.

## Configuration
- VP_RECOVERY_STATS_EN defined: stat_recoveries increments on each REDIRECT, stat_confirms on each TRACK→IDLE via vp_done, stat_stalls on each stall cycle. All 32-bit, saturating at 32'hFFFF_FFFF, reset to 0.
- Not defined: stat_* ports present and tied to 0, no counter flops.

## Structure
- Package vp_recovery_pkg: state enum vp_rec_state_e, struct undo_entry_t {reg[4:0], data[`DATA_WIDTH-1:0]}, log-pointer width localparam.
- Sub-module vp_undo_stack: LIFO of undo_entry_t with push, pop, clear, count, full and empty. Push and pop are never simultaneous. No overflow or underflow writes occur: the FSM never pushes when full or pops when empty.

## Test plan
- vp_lock, writes to r3 (old 0x11) and r5 (old 0x22), recover → undo r5=0x22 then r3=0x11, REDIRECT to predicted_pc 0x0040_0100, recovery_done one cycle.
- vp_lock, two writes, vp_done → no undo writes, no redirect, IDLE next cycle, stat_confirms=1.
- vp_lock, write to r0 and r7 twice (old 0xA then 0xB), recover → undo r7=0xB then r7=0xA only.
- LOG_DEPTH+2 writes in TRACK → stall high after 8th push, extra writes not logged, recover restores 8 entries.
- recover and vp_done together with spec_wr_valid r9 → rollback including r9.
- rst_n low during ROLLBACK → all outputs 0 asynchronously, IDLE after release, no redirect.
